seq1001_scan_ctrl: RTL and testbench
====================================

# seq1001_scan_ctrl

Scheduler and sequencer for the overlapping Moore "1001" detector. It arbitrates round-robin between two requesters, each offering a parallel word. It serialises the granted word MSB-first through an embedded 5-state 1001 detector and returns the match count plus a per-bit match map with a one-cycle done pulse. It sits between word-oriented producers and the bit-serial detection datapath, so the detector is shared without either producer handling bit timing.

## Interface
- WIDTH, 8, word length in bits (≥4); serial length per job
- CW, $clog2(WIDTH+1), match-count width (derived, not overridden)

- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous and active-low (0 = reset)
- req0  in  1  requester 0 job request; held until gnt0
- data0  in  WIDTH  requester 0 word; stable while req0 high
- req1  in  1  requester 1 job request; held until gnt1
- data1  in  WIDTH  requester 1 word; stable while req1 high
- gnt0  out  1  one-cycle pulse: requester 0 word captured
- gnt1  out  1  one-cycle pulse: requester 1 word captured
- busy  out  1  high whenever controller is not IDLE
- done  out  1  one-cycle pulse: results valid
- done_id  out  1  requester that owns the current results (0/1)
- match_cnt  out  CW  number of 1001 detections in the word
- match_map  out  WIDTH  bit i set if a detection completed on serial bit i

## Operation
- Controller FSM states:
  - IDLE: if any req is high, grant one requester and go to SHIFT.
  - SHIFT: unconditionally consume WIDTH bits, then go to DONE.
  - DONE: pulse done, then go to IDLE.
- Arbiter, round-robin:
  - A lone request is always granted.
  - If both requests are high, grant the requester not granted last.
  - Pointer resets to favour req0.
  - Request lines are ignored outside IDLE.
  - A request dropped before its grant is simply not served.
- Grant edge:
  - Capture the selected word into the shift register.
  - Record the owner id.
  - Clear the working count and map.
  - Reset the detector to state A.
- Serial order: serial bit i = data[WIDTH-1-i]; bit 0 is the MSB, shifted first.
- Embedded detector, Moore, states A–E:
  - A: 0→A, 1→B
  - B: 0→C, 1→B
  - C: 0→D, 1→B
  - D: 0→A, 1→E
  - E: 0→C, 1→B
- Detection event: every entry into E, i.e. D with bit 1. Each event increments the working count and sets working map bit i.
- Overlap is allowed: a trailing "1" starts the next match.
- Detector state never carries across words; each job starts in A.
- Result registers (done_id, match_cnt, match_map) load only on the edge entering DONE. They hold until the next DONE, so they stay readable after the done pulse.
- Count range is 0..floor((WIDTH-1)/3); CW never overflows.

## Timing
- Reset values: all outputs 0 and state IDLE. This covers gnt0, gnt1, busy, done, done_id, match_cnt and match_map. Arbiter pointer favours req0.
- Let edge t be the first edge in IDLE with a req high.
  - At edge t: gnt pulses high for the t→t+1 cycle; busy rises.
  - Edges t+1..t+WIDTH each consume one bit.
  - The last bit's detection is included in the result loaded at edge t+WIDTH.
  - done is high for cycle t+WIDTH→t+WIDTH+1.
  - At edge t+WIDTH+1: return to IDLE; busy falls.
  - The next grant is possible at edge t+WIDTH+2.
- Request-to-done latency is WIDTH+1 edges. Job throughput is one job per WIDTH+2 cycles.
- A request arriving during SHIFT or DONE waits and is evaluated in IDLE.
- Reset asserted mid-job:
  - All outputs clear asynchronously and the job is abandoned; no done is issued.
  - After release, the controller waits in IDLE.
  - An ungranted requester keeps its req high and is served normally.
- gnt0 and gnt1 are never high together.
- done and gnt are never high together.

## Test plan
- req0 with data0=8'b1001_1001: gnt0 is one cycle at edge t, done at edge t+8. Expect match_cnt=2, match_map=8'b1000_1000, done_id=0.
- Overlap, req1 with data1=8'b1001_0010: expect match_cnt=2, match_map=8'b0100_1000, done_id=1.
- After reset, req0 and req1 held together for three jobs: grant order 0, 1, 0, with successive done edges 10 cycles apart. A lone req1 after a req1 job is still granted.
- No carry across words: req0 8'b0000_0100 then 8'b1000_0000. Both jobs give match_cnt=0 and match_map=0. 8'hFF and 8'h00 each give 0.
- Deassert rst for one cycle after 4 serial bits of 8'b1001_1001: all outputs go 0 immediately and no done follows. Re-requesting yields cnt=2 normally.
- Results hold: after done, drive new req lines without granting, for example hold in reset-free IDLE with no req. match_cnt and match_map keep their last values until the next done.

Source files
------------

// File: rtl/seq1001_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq1001_scan_ctrl
//  Purpose  : Round-robin job scheduler for two word producers. It feeds the
//             granted word MSB-first through an overlapping Moore "1001"
//             detector. When the word is done it returns the match count and
//             a per-bit match map, with a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module seq1001_scan_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [CW-1:0]    match_cnt,
  output logic [WIDTH-1:0] match_map
);

  // Bit index width. It covers serial positions 0..WIDTH-1.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_e;

  // Detector states. Each name says how much of "1001" has been seen:
  //   A: nothing useful     B: "1"     C: "10"     D: "100"
  //   E: "1001" (match; a Moore output)
  typedef enum logic [2:0] {
    DET_A = 3'd0,
    DET_B = 3'd1,
    DET_C = 3'd2,
    DET_D = 3'd3,
    DET_E = 3'd4
  } det_state_e;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  ctrl_state_e      state_q,     state_d;
  det_state_e       det_q,       det_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic [IW-1:0]    bit_idx_q,   bit_idx_d;
  logic [CW-1:0]    work_cnt_q,  work_cnt_d;
  logic [WIDTH-1:0] work_map_q,  work_map_d;
  logic             owner_q,     owner_d;
  logic             last_gnt_q,  last_gnt_d;   // 1: requester 1 was served last
  logic             gnt0_q,      gnt0_d;
  logic             gnt1_q,      gnt1_d;
  logic             done_id_q,   done_id_d;
  logic [CW-1:0]    match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0] match_map_q, match_map_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       any_req;
  logic       sel1;          // arbiter picks requester 1
  logic       serial_bit;    // bit consumed on this edge
  logic       det_hit;       // this bit completes "1001"
  logic       last_bit;      // this bit is the final serial bit
  det_state_e det_next;

  // Round-robin arbiter. When both requesters ask, serve the one not served
  // last. A lone request always wins.
  always_comb begin
    any_req = req0 | req1;
    sel1    = req1 & (~req0 | ~last_gnt_q);
  end

  // Serial tap and end-of-word detect. The MSB of the shift register is
  // always the next serial bit.
  always_comb begin
    serial_bit = shreg_q[WIDTH-1];
    last_bit   = (bit_idx_q == IW'(WIDTH - 1));
  end

  // Detector next state. A hit is every entry into E, i.e. state D with a 1.
  always_comb begin
    det_next = DET_A;
    det_hit  = 1'b0;
    unique case (det_q)
      DET_A: det_next = serial_bit ? DET_B : DET_A;
      DET_B: det_next = serial_bit ? DET_B : DET_C;
      DET_C: det_next = serial_bit ? DET_B : DET_D;
      DET_D: begin
        det_next = serial_bit ? DET_E : DET_A;
        det_hit  = serial_bit;
      end
      DET_E: det_next = serial_bit ? DET_B : DET_C;
      default: det_next = DET_A;
    endcase
  end

  // Controller next state plus datapath updates. Grants, the shift work and
  // result loading all hang off the controller state.
  always_comb begin
    state_d     = state_q;
    det_d       = det_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    work_cnt_d  = work_cnt_q;
    work_map_d  = work_map_q;
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    match_map_d = match_map_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          // Capture the word and start a clean job. The detector restarts
          // in A, so no partial match carries over from the previous word.
          state_d    = ST_SHIFT;
          gnt0_d     = ~sel1;
          gnt1_d     = sel1;
          last_gnt_d = sel1;
          owner_d    = sel1;
          shreg_d    = sel1 ? data1 : data0;
          bit_idx_d  = '0;
          work_cnt_d = '0;
          work_map_d = '0;
          det_d      = DET_A;
        end
      end

      ST_SHIFT: begin
        shreg_d   = shreg_q << 1;
        det_d     = det_next;
        bit_idx_d = bit_idx_q + IW'(1);
        if (det_hit) begin
          work_cnt_d            = work_cnt_q + CW'(1);
          work_map_d[bit_idx_q] = 1'b1;
        end
        if (last_bit) begin
          // Results take the updated working values, so a hit on the last
          // bit is included.
          state_d     = ST_DONE;
          done_id_d   = owner_q;
          match_cnt_d = work_cnt_d;
          match_map_d = work_map_d;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      det_q       <= DET_A;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      work_cnt_q  <= '0;
      work_map_q  <= '0;
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b1;   // pretend requester 1 went last, so req0 wins first
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done_id_q   <= 1'b0;
      match_cnt_q <= '0;
      match_map_q <= '0;
    end else begin
      state_q     <= state_d;
      det_q       <= det_d;
      shreg_q     <= shreg_d;
      bit_idx_q   <= bit_idx_d;
      work_cnt_q  <= work_cnt_d;
      work_map_q  <= work_map_d;
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
      match_map_q <= match_map_d;
    end
  end

  // Output drive. busy and done are decoded straight from the state register.
  always_comb begin
    gnt0      = gnt0_q;
    gnt1      = gnt1_q;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    done_id   = done_id_q;
    match_cnt = match_cnt_q;
    match_map = match_map_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_seq1001_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seq1001_scan_ctrl
//  Purpose  : Self-checking bench for seq1001_scan_ctrl. The expected counts
//             and maps come from a direct pattern search over each word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq1001_scan_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [W-1:0]  data0, data1;
  logic          gnt0, gnt1, busy, done, done_id;
  logic [CW-1:0] match_cnt;
  logic [W-1:0]  match_map;

  int tests_run;
  int tests_failed;

  seq1001_scan_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .data0     (data0),
    .req1      (req1),
    .data1     (data1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt),
    .match_map (match_map)
  );

  always #5 clk = ~clk;

  // Reference: serial position i carries word bit W-1-i. A detection ends at
  // position i when positions i-3..i read 1,0,0,1 (overlap allowed).
  function automatic void model(input logic [W-1:0] w, output int c, output logic [W-1:0] m);
    logic [W-1:0] s;
    c = 0;
    m = '0;
    for (int i = 0; i < W; i++) s[i] = w[W-1-i];
    for (int i = 3; i < W; i++)
      if (s[i-3] && !s[i-2] && !s[i-1] && s[i]) begin
        c++;
        m[i] = 1'b1;
      end
  endfunction

  // Runs one job from a negedge: raise the request, wait for its grant, then
  // wait for done. Returns what was seen, and ends on a negedge.
  task automatic run_job(input int who, input logic [W-1:0] d,
                         output bit granted, output int lat,
                         output logic [CW-1:0] cnt, output logic [W-1:0] map,
                         output logic id, output bit clean,
                         output logic busy_g, output logic busy_after);
    int n;
    granted = 0; lat = 0; clean = 1; cnt = 'x; map = 'x; id = 1'bx;
    busy_g = 1'b0; busy_after = 1'bx;
    if (who == 0) begin req0 = 1'b1; data0 = d; end
    else          begin req1 = 1'b1; data1 = d; end
    n = 0;
    while (!granted && n < 30) begin
      @(negedge clk); n++;
      if (gnt0 && gnt1) clean = 0;
      if ((who == 0) ? gnt0 : gnt1) begin
        granted = 1;
        busy_g  = busy;
        if (done) clean = 0;
      end
    end
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    if (granted) begin
      while (lat < 30) begin
        @(negedge clk); lat++;
        if (gnt0 || gnt1) clean = 0;
        if (done) break;
      end
      cnt = match_cnt; map = match_map; id = done_id;
      @(negedge clk);
      busy_after = busy;
      if (done) clean = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({gnt0, gnt1, busy, done, done_id, match_cnt, match_map} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%h exp=0", {gnt0, gnt1, busy, done, done_id, match_cnt, match_map});
    end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    bit g, cl; int lat; logic [CW-1:0] c; logic [W-1:0] m; logic id, bg, ba;
    run_job(0, 8'b1001_1001, g, lat, c, m, id, cl, bg, ba);
    tests_run++;
    if (!g || lat !== W || !cl || bg !== 1'b1 || ba !== 1'b0) begin
      tests_failed++;
      $display("FAIL dir0_timing got g=%0d lat=%0d clean=%0d busy=%b/%b exp g=1 lat=%0d clean=1 busy=1/0", g, lat, cl, bg, ba, W);
    end
    tests_run++;
    if (c !== CW'(2) || m !== 8'b1000_1000 || id !== 1'b0) begin
      tests_failed++;
      $display("FAIL dir0_result got cnt=%0d map=%b id=%b exp cnt=2 map=10001000 id=0", c, m, id);
    end
    run_job(1, 8'b1001_0010, g, lat, c, m, id, cl, bg, ba);
    tests_run++;
    if (!g || lat !== W || !cl || c !== CW'(2) || m !== 8'b0100_1000 || id !== 1'b1) begin
      tests_failed++;
      $display("FAIL dir1_overlap got g=%0d lat=%0d cnt=%0d map=%b id=%b exp g=1 lat=%0d cnt=2 map=01001000 id=1", g, lat, c, m, id, W);
    end
  endtask

  task automatic test_round_robin();
    int gids[3], dids[3], dt[3], ng, nd, cyc, ec;
    logic [W-1:0] em, wd;
    bit g, cl; int lat; logic [CW-1:0] c; logic [W-1:0] m; logic id, bg, ba;
    // fresh reset so the pointer starts out favouring req0
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    data0 = 8'b1001_1001; data1 = 8'b1001_0010;
    req0 = 1'b1; req1 = 1'b1;
    ng = 0; nd = 0; cyc = 0;
    while ((ng < 3 || nd < 3) && cyc < 60) begin
      @(negedge clk); cyc++;
      if (gnt0 && gnt1) begin
        tests_run++; tests_failed++;
        $display("FAIL rr_exclusive got gnt0=1 gnt1=1 exp one-hot");
      end
      if (gnt0 && ng < 3) begin gids[ng] = 0; ng++; end
      if (gnt1 && ng < 3) begin gids[ng] = 1; ng++; end
      if (ng == 3) begin req0 = 1'b0; req1 = 1'b0; end
      if (done && nd < 3) begin
        dt[nd] = cyc; dids[nd] = int'(done_id);
        wd = done_id ? data1 : data0;
        model(wd, ec, em);
        tests_run++;
        if (match_cnt !== CW'(ec) || match_map !== em) begin
          tests_failed++;
          $display("FAIL rr_result%0d got cnt=%0d map=%b exp cnt=%0d map=%b", nd, match_cnt, match_map, ec, em);
        end
        nd++;
      end
    end
    tests_run++;
    if (ng != 3 || nd != 3 || gids[0] != 0 || gids[1] != 1 || gids[2] != 0) begin
      tests_failed++;
      $display("FAIL rr_order got n=%0d/%0d order=%0d%0d%0d exp 010", ng, nd, gids[0], gids[1], gids[2]);
    end
    tests_run++;
    if (nd != 3 || dids[0] != 0 || dids[1] != 1 || dids[2] != 0 ||
        dt[1] - dt[0] != W + 2 || dt[2] - dt[1] != W + 2) begin
      tests_failed++;
      $display("FAIL rr_done got ids=%0d%0d%0d gaps=%0d,%0d exp ids=010 gaps=%0d", dids[0], dids[1], dids[2], dt[1]-dt[0], dt[2]-dt[1], W+2);
    end
    @(negedge clk);
    // a lone req1 after a req1 job is still served
    run_job(1, 8'h12, g, lat, c, m, id, cl, bg, ba);
    run_job(1, 8'h93, g, lat, c, m, id, cl, bg, ba);
    model(8'h93, ec, em);
    tests_run++;
    if (!g || id !== 1'b1 || c !== CW'(ec) || m !== em) begin
      tests_failed++;
      $display("FAIL rr_lone_req1 got g=%0d id=%b cnt=%0d map=%b exp g=1 id=1 cnt=%0d map=%b", g, id, c, m, ec, em);
    end
  endtask

  task automatic test_no_carry();
    logic [W-1:0] words[4];
    bit g, cl; int lat; logic [CW-1:0] c; logic [W-1:0] m; logic id, bg, ba;
    words[0] = 8'b0000_0100; words[1] = 8'b1000_0000; words[2] = 8'hFF; words[3] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      run_job(0, words[k], g, lat, c, m, id, cl, bg, ba);
      tests_run++;
      if (!g || c !== '0 || m !== '0) begin
        tests_failed++;
        $display("FAIL no_carry%0d word=%b got g=%0d cnt=%0d map=%b exp cnt=0 map=0", k, words[k], g, c, m);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit g, cl, seen; int lat, n; logic [CW-1:0] c; logic [W-1:0] m; logic id, bg, ba;
    req0 = 1'b1; data0 = 8'b1001_1001;
    seen = 0; n = 0;
    while (!seen && n < 30) begin @(negedge clk); n++; if (gnt0) seen = 1; end
    req0 = 1'b0;
    req1 = 1'b1; data1 = 8'b1001_0010;   // waits: not granted outside IDLE
    repeat (4) @(negedge clk);
    tests_run++;
    if (!seen || busy !== 1'b1 || gnt1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_pre got seen=%0d busy=%b gnt1=%b exp 1/1/0", seen, busy, gnt1);
    end
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if ({gnt0, gnt1, busy, done, done_id, match_cnt, match_map} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_async got=%h exp=0", {gnt0, gnt1, busy, done, done_id, match_cnt, match_map});
    end
    @(negedge clk); rst = 1'b1;
    // the held req1 is served; an early done would show as a short latency
    run_job(1, 8'b1001_0010, g, lat, c, m, id, cl, bg, ba);
    tests_run++;
    if (!g || lat !== W || !cl || c !== CW'(2) || m !== 8'b0100_1000 || id !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_req1 got g=%0d lat=%0d cnt=%0d map=%b id=%b exp g=1 lat=%0d cnt=2 map=01001000 id=1", g, lat, c, m, id, W);
    end
    run_job(0, 8'b1001_1001, g, lat, c, m, id, cl, bg, ba);
    tests_run++;
    if (!g || lat !== W || c !== CW'(2) || m !== 8'b1000_1000 || id !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_rerun got g=%0d lat=%0d cnt=%0d map=%b id=%b exp cnt=2 map=10001000 id=0", g, lat, c, m, id);
    end
  endtask

  task automatic test_hold();
    int n, dones; bit seen;
    // last job gave cnt=2 map=10001000 id=0
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      data0 = W'($urandom); data1 = W'($urandom);
      @(negedge clk);
      if (done) dones++;
    end
    tests_run++;
    if (dones != 0 || match_cnt !== CW'(2) || match_map !== 8'b1000_1000 || done_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_idle got dones=%0d cnt=%0d map=%b id=%b exp 0/2/10001000/0", dones, match_cnt, match_map, done_id);
    end
    req1 = 1'b1; data1 = 8'hFF;
    seen = 0; n = 0;
    while (!seen && n < 30) begin @(negedge clk); n++; if (gnt1) seen = 1; end
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (!seen || match_cnt !== CW'(2) || match_map !== 8'b1000_1000 || done_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_shift got seen=%0d cnt=%0d map=%b id=%b exp 1/2/10001000/0", seen, match_cnt, match_map, done_id);
    end
    n = 0;
    while (!done && n < 30) begin @(negedge clk); n++; end
    tests_run++;
    if (!done || match_cnt !== '0 || match_map !== '0 || done_id !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_next got done=%b cnt=%0d map=%b id=%b exp 1/0/0/1", done, match_cnt, match_map, done_id);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit g, cl; int lat, ec, who; logic [CW-1:0] c; logic [W-1:0] m, em, d; logic id, bg, ba;
    for (int k = 0; k < 24; k++) begin
      who = int'($urandom_range(0, 1));
      d   = W'($urandom);
      if (k % 4 == 0) d = {d[W-1:4], 4'b1001};   // bias towards matches
      model(d, ec, em);
      run_job(who, d, g, lat, c, m, id, cl, bg, ba);
      tests_run++;
      if (!g || lat !== W || !cl || ba !== 1'b0 || c !== CW'(ec) || m !== em || id !== 1'(who)) begin
        tests_failed++;
        $display("FAIL random%0d who=%0d word=%b got g=%0d lat=%0d clean=%0d cnt=%0d map=%b id=%b exp lat=%0d cnt=%0d map=%b", k, who, d, g, lat, cl, c, m, id, W, ec, em);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_round_robin();
    test_no_carry();
    test_mid_reset();
    test_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
